// File: rtl/input_cond_pkg.sv
// -----------------------------------------------------------------------------
// input_cond_pkg
// Shared definitions for the pad input-conditioning blocks: the debounce state
// encoding, default parameter values and the counter-width helper.
// -----------------------------------------------------------------------------
package input_cond_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int GLITCH_W_DEF        = 8;

    // state      | meaning
    // STABLE_LO  | accepted level is 0, synchronised input agrees
    // CHK_HI     | accepted level is 0, counting consecutive 1 samples
    // STABLE_HI  | accepted level is 1, synchronised input agrees
    // CHK_LO     | accepted level is 1, counting consecutive 0 samples
    //
    // Bit 1 of the encoding is the accepted level, so the state register
    // doubles as the registered clean output.
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHK_HI    = 2'b01,
        STABLE_HI = 2'b11,
        CHK_LO    = 2'b10
    } deb_state_t;

    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Plain multi-flop synchroniser for an asynchronous pad input. No logic sits
// between the flops so the chain can be constrained as a synchroniser.
//
// Ports:
//   clk    in   sampling clock
//   reset  in   synchronous reset, active-high; clears every flop
//   d      in   asynchronous input
//   q      out  input delayed through SYNC_STAGES flops
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// -----------------------------------------------------------------------------
// input_debounce
// Synchronises and debounces the raw pad input feeding the history-FSM core.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive agreeing
// synchronised samples; an aborted check is counted as a glitch.
//
// Ports:
//   clk           in   sole clock
//   reset         in   synchronous reset, active-high
//   a_raw         in   unsynchronised pad input
//   a_clean       out  debounced level (registered)
//   a_rise        out  one-cycle pulse coincident with a_clean 0->1
//   a_fall        out  one-cycle pulse coincident with a_clean 1->0
//   glitch_count  out  rejected transitions, saturating
//
// state      | meaning
// STABLE_LO  | level 0 accepted, input agrees
// CHK_HI     | level 0 accepted, qualifying a rising input
// STABLE_HI  | level 1 accepted, input agrees
// CHK_LO     | level 1 accepted, qualifying a falling input
// -----------------------------------------------------------------------------
module input_debounce
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int GLITCH_W        = GLITCH_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_raw,
    output logic                a_clean,
    output logic                a_rise,
    output logic                a_fall,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int                 CNT_W      = cnt_width(DEBOUNCE_CYCLES);
    // The counter holds the number of agreeing samples seen so far, so the
    // check completes when the stored count already equals DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    logic                w_s;
    deb_state_t          r_state;
    deb_state_t          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_glitch;
    logic                r_rise;
    logic                r_fall;
    logic [GLITCH_W-1:0] r_glitch;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (a_raw),
        .q     (w_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_glitch    = 1'b0;
        unique case (r_state)
            STABLE_LO: begin
                if (w_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt = STABLE_HI;
                    end else begin
                        w_state_nxt = CHK_HI;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            CHK_HI: begin
                if (!w_s) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                    w_glitch    = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!w_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt = STABLE_LO;
                    end else begin
                        w_state_nxt = CHK_LO;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            CHK_LO: begin
                if (w_s) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                    w_glitch    = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= STABLE_LO;
            r_cnt    <= '0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            // Pulses follow the accepted level, so an aborted check (which
            // returns to the stable state it left) never produces one.
            r_rise   <= w_state_nxt[1] & ~r_state[1];
            r_fall   <= ~w_state_nxt[1] & r_state[1];
            if (w_glitch && (r_glitch != GLITCH_MAX)) begin
                r_glitch <= r_glitch + 1'b1;
            end
        end
    end

    assign a_clean      = r_state[1];
    assign a_rise       = r_rise;
    assign a_fall       = r_fall;
    assign glitch_count = r_glitch;

endmodule

// File: tb/tb_input_debounce.sv
module tb_input_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_raw;
    logic       a_clean, a_rise, a_fall;
    logic [7:0] glitch_count;
    logic       a_clean1, a_rise1, a_fall1;
    logic [7:0] glitch_count1;

    always #5 clk = ~clk;

    input_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .GLITCH_W        (8)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .a_raw        (a_raw),
        .a_clean      (a_clean),
        .a_rise       (a_rise),
        .a_fall       (a_fall),
        .glitch_count (glitch_count)
    );

    input_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1),
        .GLITCH_W        (8)
    ) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .a_raw        (a_raw),
        .a_clean      (a_clean1),
        .a_rise       (a_rise1),
        .a_fall       (a_fall1),
        .glitch_count (glitch_count1)
    );

    typedef struct {
        logic       clean;
        logic       rise;
        logic       fall;
        logic [7:0] glitch;
    } exp_t;

    typedef struct {
        logic rst;
        logic raw;
        exp_t e;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rise = 0;
    int   n_fall = 0;

    function automatic exp_t mk(input logic c, input logic r, input logic f, input logic [7:0] g);
        exp_t x;
        x.clean  = c;
        x.rise   = r;
        x.fall   = f;
        x.glitch = g;
        return x;
    endfunction

    task automatic add(input logic rst, input logic raw, input logic c, input logic r,
                       input logic f, input logic [7:0] g);
        vec_t v;
        v.rst = rst;
        v.raw = raw;
        v.e   = mk(c, r, f, g);
        tbl.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Drive one cycle of stimulus, queue what the main DUT must show after the
    // edge, then pop and compare once the edge has happened.
    task automatic step(input string tag, input logic rst, input logic raw, input exp_t e);
        exp_t x;
        reset = rst;
        a_raw = raw;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (a_rise) n_rise++;
        if (a_fall) n_fall++;
        x = sb_q.pop_front();
        n_cmp++;
        if ({a_clean, a_rise, a_fall, glitch_count} !== {x.clean, x.rise, x.fall, x.glitch}) begin
            n_bad++;
            $display("FAIL %s @%0t: clean/rise/fall/glitch got %b/%b/%b/%0d want %b/%b/%b/%0d",
                     tag, $time, a_clean, a_rise, a_fall, glitch_count,
                     x.clean, x.rise, x.fall, x.glitch);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp1 [0:8];
        logic       raw_t [0:99];
        logic       prev_c, cur_c;
        int         g_lo, g_hi;

        reset = 1'b1;
        a_raw = 1'b0;

        // reset: two edges with reset held
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        // rise latency: raw=1 before edge 1, level appears after edge 6
        for (int k = 1; k <= 5; k++) add(0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        // two-cycle low glitch while high
        add(0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 1);
        // clean fall with same latency
        for (int k = 1; k <= 5; k++) add(0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1);
        // reset at edge 4 of a rising check, then full latency again
        for (int k = 1; k <= 3; k++) add(0, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) add(0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0);

        // DEBOUNCE_CYCLES=1 instance over the first nine rows: {clean, rise}
        exp1[0] = 2'b00; exp1[1] = 2'b00; exp1[2] = 2'b00; exp1[3] = 2'b00;
        exp1[4] = 2'b11; exp1[5] = 2'b10; exp1[6] = 2'b10; exp1[7] = 2'b10;
        exp1[8] = 2'b10;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].raw, tbl[i].e);
            if (i < 9) begin
                chk($sformatf("d1_vec%0d", i),
                    {28'd0, a_clean1, a_rise1, a_fall1, (glitch_count1 != 8'd0)},
                    {28'd0, exp1[i], 2'b00});
            end
        end

        // toggle every 10 cycles from a settled high: level lags input by 6 edges
        for (int i = 0; i < 100; i++) raw_t[i] = ((i / 10) % 2 == 1);
        n_rise = 0;
        n_fall = 0;
        prev_c = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            cur_c = (k < 6) ? 1'b1 : raw_t[k-6];
            step($sformatf("tog%0d", k), 1'b0, raw_t[k-1],
                 mk(cur_c, cur_c & ~prev_c, ~cur_c & prev_c, 8'd0));
            prev_c = cur_c;
        end
        chk("tog_rise_count", n_rise, 5);
        chk("tog_fall_count", n_fall, 5);
        chk("tog_glitch", {24'd0, glitch_count}, 0);

        // 300 single-cycle pulses separated by 8 low cycles: saturating count
        step("pulse_reset", 1'b1, 1'b0, mk(0, 0, 0, 8'd0));
        for (int p = 0; p < 300; p++) begin
            g_lo = (p > 255) ? 255 : p;
            g_hi = (p + 1 > 255) ? 255 : p + 1;
            for (int e = 1; e <= 9; e++) begin
                step($sformatf("pulse%0d_e%0d", p, e), 1'b0, (e == 1),
                     mk(0, 0, 0, (e < 4) ? g_lo[7:0] : g_hi[7:0]));
            end
        end
        chk("glitch_saturated", {24'd0, glitch_count}, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
